// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time controller for divide-by-N tick generation.
//
// A programmable modulo counter runs while the controller is in RUN and
// emits a one-cycle tick at phase 0 of every period. Divisor and burst
// length arrive over a valid/ready port; in IDLE they are written directly,
// in RUN they are held in a one-deep shadow and applied at a period
// boundary (the wrap), so a period is never stretched or truncated.
//
// Optional build macro: CLKDIV_CTRL_ERR_EN
//   When defined, adds a sticky error flag (err) with a clear input
//   (err_clr). The flag records config offers that stall against a full
//   shadow and accepted divisors below 2 that were clamped.

module clkdiv_ctrl #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8,
    parameter int DIV_RST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
`ifdef CLKDIV_CTRL_ERR_EN
    output logic               err,
    input  logic               err_clr,
`endif
    output logic               tick,
    output logic [CNT_W-1:0]   phase,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Divisors below 2 would make phase 0 and the wrap the same cycle.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        if (d < CNT_W'(2)) begin
            return CNT_W'(2);
        end
        return d;
    endfunction

    // Tick counter holds at its maximum instead of rolling over.
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + BURST_W'(1);
    endfunction

    state_t             state, state_nx;
    logic [CNT_W-1:0]   phase_nx;
    logic [CNT_W-1:0]   div_r, div_nx;
    logic [BURST_W-1:0] burst_r, burst_nx;
    logic [CNT_W-1:0]   shd_div, shd_div_nx;
    logic [BURST_W-1:0] shd_burst, shd_burst_nx;
    logic               shd_valid, shd_valid_nx;
    logic               stop_pend, stop_nx;
    logic [BURST_W-1:0] tick_cnt, cnt_nx;
    logic               done_nx;

    logic               cfg_xfer;
    logic               wrap;
    logic               burst_hit;
    logic               terminate;

    // The shadow is only ever occupied in RUN, so this is 1 throughout IDLE.
    assign cfg_ready = !shd_valid;
    assign cfg_xfer  = cfg_valid && cfg_ready;

    assign busy      = (state == RUN);
    assign tick      = (state == RUN) && (phase == '0);
    assign wrap      = (state == RUN) && (phase == (div_r - CNT_W'(1)));
    assign burst_hit = (burst_r != '0) && (tick_cnt == burst_r);
    assign terminate = wrap && (stop_pend || burst_hit);

    // Next-state and next-register computation for the run controller.
    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        div_nx       = div_r;
        burst_nx     = burst_r;
        shd_div_nx   = shd_div;
        shd_burst_nx = shd_burst;
        shd_valid_nx = shd_valid;
        stop_nx      = stop_pend;
        cnt_nx       = tick_cnt;
        done_nx      = 1'b0;

        unique case (state)
            IDLE: begin
                // Config takes effect directly while stopped.
                if (cfg_xfer) begin
                    div_nx   = clamp_div(cfg_div);
                    burst_nx = cfg_burst;
                end
                // start wins over a simultaneous stop: stop is ignored here.
                if (start) begin
                    state_nx = RUN;
                    phase_nx = '0;
                    cnt_nx   = '0;
                    stop_nx  = 1'b0;
                end
            end

            RUN: begin
                if (stop) begin
                    stop_nx = 1'b1;
                end
                if (tick) begin
                    cnt_nx = sat_inc(tick_cnt);
                end

                if (wrap) begin
                    phase_nx = '0;
                    // A shadow loaded in an earlier cycle lands at this boundary
                    // and restarts burst accounting under the new settings.
                    if (shd_valid) begin
                        div_nx       = shd_div;
                        burst_nx     = shd_burst;
                        shd_valid_nx = 1'b0;
                        cnt_nx       = '0;
                    end
                    if (terminate) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        stop_nx  = 1'b0;
                        // No later boundary exists, so an offer taken on the
                        // final wrap is applied on entry to IDLE.
                        if (cfg_xfer) begin
                            div_nx   = clamp_div(cfg_div);
                            burst_nx = cfg_burst;
                        end
                    end else if (cfg_xfer) begin
                        // Taken on a wrap: waits for the following wrap.
                        shd_div_nx   = clamp_div(cfg_div);
                        shd_burst_nx = cfg_burst;
                        shd_valid_nx = 1'b1;
                    end
                end else begin
                    phase_nx = phase + CNT_W'(1);
                    if (cfg_xfer) begin
                        shd_div_nx   = clamp_div(cfg_div);
                        shd_burst_nx = cfg_burst;
                        shd_valid_nx = 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counter, active configuration, shadow and run bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            div_r     <= CNT_W'(DIV_RST);
            burst_r   <= '0;
            shd_div   <= '0;
            shd_burst <= '0;
            shd_valid <= 1'b0;
            stop_pend <= 1'b0;
            tick_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            phase     <= phase_nx;
            div_r     <= div_nx;
            burst_r   <= burst_nx;
            shd_div   <= shd_div_nx;
            shd_burst <= shd_burst_nx;
            shd_valid <= shd_valid_nx;
            stop_pend <= stop_nx;
            tick_cnt  <= cnt_nx;
            done      <= done_nx;
        end
    end

`ifdef CLKDIV_CTRL_ERR_EN
    logic err_set;

    assign err_set = (cfg_valid && !cfg_ready) ||
                     (cfg_xfer && (cfg_div < CNT_W'(2)));

    // Sticky error flag; a set event in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios followed by
// randomized runs, compared each cycle against a period-level reference
// model (period start time, tick totals, a queue for pending config).

module tb_clkdiv_ctrl;

    localparam int CNT_W   = 8;
    localparam int BURST_W = 8;
    localparam int DIV_RST = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [CNT_W-1:0]   cfg_div = '0;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               cfg_ready;
    logic               tick;
    logic [CNT_W-1:0]   phase;
    logic               busy;
    logic               done;
`ifdef CLKDIV_CTRL_ERR_EN
    logic               err;
    logic               err_clr = 1'b0;
`endif

    clkdiv_ctrl #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
`ifdef CLKDIV_CTRL_ERR_EN
        .err       (err),
        .err_clr   (err_clr),
`endif
        .tick      (tick),
        .phase     (phase),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int div;
        int burst;
    } cfg_t;

    // Reference model: a run is a sequence of periods; phase is the time
    // elapsed since the current period began.
    int   cyc;
    int   m_run;
    int   m_pstart;
    int   m_div;
    int   m_burst;
    int   m_ticks;
    int   m_stop;
    int   m_done;
    int   m_err;
    cfg_t m_shq[$];

    int n_vec = 0;
    int n_mis = 0;
    int obs_ticks = 0;
    int obs_dones = 0;
    int last_done = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clampi(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int mphase();
        return m_run != 0 ? (cyc - m_pstart) : 0;
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_pstart = 0;
        m_div    = DIV_RST;
        m_burst  = 0;
        m_ticks  = 0;
        m_stop   = 0;
        m_done   = 0;
        m_err    = 0;
        m_shq.delete();
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model.
    task automatic do_cycle();
        int   ph;
        int   etick;
        int   eready;
        int   acc;
        int   wrap;
        int   term;
        cfg_t c;
        @(negedge clk);
        ph     = mphase();
        etick  = (m_run != 0 && ph == 0) ? 1 : 0;
        eready = (m_shq.size() == 0) ? 1 : 0;
        check("tick", tick, etick);
        check("phase", phase, ph);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("cfg_ready", cfg_ready, eready);
`ifdef CLKDIV_CTRL_ERR_EN
        check("err", err, m_err);
`endif
        if (tick === 1'b1) obs_ticks++;
        if (done === 1'b1) begin
            obs_dones++;
            last_done = cyc;
        end

        acc = (cfg_valid && eready != 0) ? 1 : 0;
`ifdef CLKDIV_CTRL_ERR_EN
        if ((cfg_valid && eready == 0) || (acc != 0 && int'(cfg_div) < 2))
            m_err = 1;
        else if (err_clr)
            m_err = 0;
`endif
        c.div   = clampi(int'(cfg_div));
        c.burst = int'(cfg_burst);
        m_done  = 0;
        if (m_run == 0) begin
            if (acc != 0) begin
                m_div   = c.div;
                m_burst = c.burst;
            end
            if (start) begin
                m_run    = 1;
                m_pstart = cyc + 1;
                m_ticks  = 0;
                m_stop   = 0;
            end
        end else begin
            wrap = (ph == m_div - 1) ? 1 : 0;
            term = (wrap != 0 && (m_stop != 0 || (m_burst != 0 && m_ticks == m_burst))) ? 1 : 0;
            if (etick != 0) m_ticks++;
            if (stop) m_stop = 1;
            if (wrap != 0) begin
                if (m_shq.size() > 0) begin
                    m_div   = m_shq[0].div;
                    m_burst = m_shq[0].burst;
                    void'(m_shq.pop_front());
                    m_ticks = 0;
                end
                m_pstart = cyc + 1;
                if (term != 0) begin
                    m_run  = 0;
                    m_done = 1;
                    m_stop = 0;
                    if (acc != 0) begin
                        m_div   = c.div;
                        m_burst = c.burst;
                    end
                end else if (acc != 0) begin
                    m_shq.push_back(c);
                end
            end else if (acc != 0) begin
                m_shq.push_back(c);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef CLKDIV_CTRL_ERR_EN
        err_clr   = 1'b0;
`endif
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) do_cycle();
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 64 && mphase() != p; k++) do_cycle();
        check("wait_phase", phase, p);
    endtask

    // Bounded wait for the run to end, plus the cycle that shows done.
    task automatic run_until_idle(input int limit);
        for (int k = 0; k < limit && m_run != 0; k++) do_cycle();
        do_cycle();
        check("idle_bound", busy, 0);
    endtask

    task automatic offer(input int d, input int b);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(d);
        cfg_burst = BURST_W'(b);
        do_cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
        run_until_idle(300);
    endtask

    int s;
    int t0;
    int d0;

    initial begin
        cyc = 0;
        model_reset();

        // Reset state, sampled while reset is held.
        repeat (2) @(posedge clk);
        #2;
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_phase", phase, 0);
        check("rst_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Continuous run, divide by 3.
        offer(3, 0);
        start = 1'b1;
        s = cyc;
        do_cycle();
        start = 1'b0;
        t0 = obs_ticks;
        d0 = obs_dones;
        run_cycles(10);
        check("cont_ticks", obs_ticks - t0, 4);
        check("cont_no_done", obs_dones - d0, 0);
        stop_run();

        // Burst of two at divide by 5.
        offer(5, 2);
        start = 1'b1;
        s = cyc;
        do_cycle();
        start = 1'b0;
        t0 = obs_ticks;
        run_until_idle(40);
        check("burst_ticks", obs_ticks - t0, 2);
        check("burst_done_cyc", last_done - s, 11);

        // Mid-period reconfigure from 4 to 2.
        offer(4, 0);
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        wait_phase(1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd2;
        cfg_burst = 8'd0;
        do_cycle();
        cfg_valid = 1'b0;
        check("shadow_full", cfg_ready, 0);
        run_cycles(12);
        stop_run();

        // Graceful stop at phase 2 of a divide-by-6 period, start ignored.
        offer(6, 0);
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        run_cycles(3);
        wait_phase(2);
        s = cyc;
        t0 = obs_ticks;
        stop  = 1'b1;
        start = 1'b1;
        do_cycle();
        stop  = 1'b0;
        start = 1'b0;
        run_until_idle(20);
        check("stop_ticks", obs_ticks - t0, 0);
        check("stop_done_cyc", last_done - s, 4);

        // Divisor 1 clamps to 2.
        offer(1, 0);
`ifdef CLKDIV_CTRL_ERR_EN
        check("err_set", err, 1);
        err_clr = 1'b1;
        do_cycle();
        err_clr = 1'b0;
        check("err_cleared", err, 0);
`endif
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        t0 = obs_ticks;
        run_cycles(8);
        check("clamp_ticks", obs_ticks - t0, 4);
        stop_run();

        // Asynchronous reset mid-run at phase 3.
        offer(7, 0);
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        wait_phase(3);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_phase", phase, 0);
        check("arst_ready", cfg_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        t0 = obs_ticks;
        run_cycles(9);
        check("post_rst_ticks", obs_ticks - t0, 3);
        stop_run();

        // Randomized runs.
        for (int r = 0; r < 30; r++) begin
            stop = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                offer(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
            end
            stop  = 1'b0;
            start = 1'b1;
            do_cycle();
            start = 1'b0;
            for (int k = 0; k < 80 && m_run != 0; k++) begin
                cfg_valid = ($urandom_range(0, 5) == 0);
                cfg_div   = CNT_W'($urandom_range(0, 9));
                cfg_burst = BURST_W'($urandom_range(0, 4));
                stop      = (k > 50) || ($urandom_range(0, 39) == 0);
                start     = ($urandom_range(0, 9) == 0);
`ifdef CLKDIV_CTRL_ERR_EN
                err_clr   = ($urandom_range(0, 7) == 0);
`endif
                do_cycle();
            end
            idle_inputs();
            run_until_idle(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
